// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the pipelined processor: opcodes, instruction-type codes
// and the default datapath widths used by the fetch stage.
package riscv_pipe_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_ADDR_W = 10;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } instr_type_e;

    function automatic logic [5:0] opcode_of(input logic [DEF_XLEN-1:0] ir);
        return ir[DEF_XLEN-1 -: 6];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two prefetch queue with synchronous flush; a push into a full queue
// is accepted only when a pop frees the head slot in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted valid.
    always_ff @(posedge clk1) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage: prefetches into a small queue, handles branch
// redirects with a same-cycle refetch, and stops permanently on halt.
module pipe_fetch_unit
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_ir,
    output logic [ADDR_W-1:0] id_npc,
    output logic              id_flush,
    output logic              halted
);
    localparam int CW = $clog2(DEPTH) + 2;
    localparam int EW = XLEN + ADDR_W;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              inflight_r;
    logic              epoch_r;
    logic              req_epoch_r;
    logic              halted_r;

    logic              redirect_act_s;
    logic              valid_s;
    logic              pop_s;
    logic              push_s;
    logic              req_s;
    logic [ADDR_W-1:0] addr_s;
    logic [CW-1:0]     occupancy_s;
    logic [CW-2:0]     fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [EW-1:0]     head_s;

    // Request/handshake decisions. A slot freed by this cycle's pop is reusable
    // immediately, which keeps DEPTH=2 at one instruction per cycle.
    always_comb begin
        redirect_act_s = rst_n && redirect_valid && !halted_r && !halt;
        valid_s        = !fifo_empty_s && !redirect_valid && !halted_r;
        pop_s          = valid_s && id_ready;
        push_s         = inflight_r && (req_epoch_r == epoch_r) && !halted_r && !halt
                         && !redirect_act_s && (!fifo_full_s || pop_s);
        occupancy_s    = CW'(fifo_count_s) + CW'(inflight_r) - CW'(pop_s);
        addr_s         = redirect_act_s ? redirect_pc : pc_r;
        if (!rst_n || halted_r || halt) begin
            req_s = 1'b0;
        end else if (redirect_valid) begin
            req_s = 1'b1;
        end else begin
            req_s = (occupancy_s < CW'(DEPTH));
        end
    end

    // Fetch PC, in-flight tracking, epoch and sticky halt.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= ADDR_W'(RESET_PC);
            req_addr_r  <= ADDR_W'(0);
            inflight_r  <= 1'b0;
            epoch_r     <= 1'b0;
            req_epoch_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            halted_r   <= halted_r | halt;
            epoch_r    <= epoch_r ^ redirect_act_s;
            inflight_r <= req_s;
            if (req_s) begin
                pc_r        <= addr_s + ADDR_W'(1);
                req_addr_r  <= addr_s;
                req_epoch_r <= epoch_r ^ redirect_act_s;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_act_s),
        .wdata ({imem_rdata, req_addr_r + ADDR_W'(1)}),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign imem_req  = req_s;
    assign imem_addr = addr_s;
    assign id_valid  = valid_s;
    assign id_ir     = valid_s ? head_s[EW-1 -: XLEN] : {XLEN{1'b0}};
    assign id_npc    = valid_s ? head_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
    assign id_flush  = redirect_act_s;
    assign halted    = halted_r;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: directed scenarios plus randomized ready/redirect
// traffic checked against an in-order instruction-stream model.
module tb_pipe_fetch_unit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [9:0]  id_npc;
    logic        id_flush;
    logic        halted;

    logic        imem_req_w;
    logic [3:0]  imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w = 1'b0;
    logic [3:0]  redirect_pc_w = 4'd0;
    logic        halt_w = 1'b0;
    logic        id_ready_w = 1'b1;
    logic        id_valid_w;
    logic [31:0] id_ir_w;
    logic [3:0]  id_npc_w;
    logic        id_flush_w;
    logic        halted_w;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_errors = 0;
    int exp_pc   = 0;
    int fetch_pc = 0;
    int hs_count = 0;
    int n_req    = 0;

    always #5 clk1 = ~clk1;

    pipe_fetch_unit dut (
        .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .id_ready(id_ready), .id_valid(id_valid), .id_ir(id_ir),
        .id_npc(id_npc), .id_flush(id_flush), .halted(halted)
    );

    pipe_fetch_unit #(.ADDR_W(4), .RESET_PC(14)) dut_w (
        .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .halt(halt_w), .id_ready(id_ready_w), .id_valid(id_valid_w), .id_ir(id_ir_w),
        .id_npc(id_npc_w), .id_flush(id_flush_w), .halted(halted_w)
    );

    // Instruction memories: read data one cycle after the strobe.
    always @(posedge clk1) begin
        if (imem_req)   imem_rdata   <= mem[imem_addr];
        if (imem_req_w) imem_rdata_w <= 32'hCAFE0000 | 32'(imem_addr_w);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: ID sees consecutive addresses from the last redirect/reset target.
    task automatic sb_cycle();
        if (redirect_valid) begin
            check("flush_on_redirect", 64'(id_flush), 64'd1);
            check("no_valid_on_redirect", 64'(id_valid), 64'd0);
            check("req_on_redirect", 64'(imem_req), 64'd1);
            check("req_addr_redirect", 64'(imem_addr), 64'(redirect_pc));
            exp_pc   = int'(redirect_pc);
            fetch_pc = (int'(redirect_pc) + 1) % 1024;
        end else begin
            if (id_valid && id_ready) begin
                check("hs_ir", 64'(id_ir), 64'(mem[exp_pc]));
                check("hs_npc", 64'(id_npc), 64'((exp_pc + 1) % 1024));
                exp_pc = (exp_pc + 1) % 1024;
                hs_count++;
            end
            if (imem_req) begin
                check("req_addr_seq", 64'(imem_addr), 64'(fetch_pc));
                fetch_pc = (fetch_pc + 1) % 1024;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        @(negedge clk1);
    endtask

    task automatic release_reset();
        @(negedge clk1);
        rst_n    = 1'b1;
        exp_pc   = 0;
        fetch_pc = 0;
        hs_count = 0;
    endtask

    initial begin
        logic [31:0] tmp;
        for (int i = 0; i < 1024; i++) begin
            tmp = $urandom;
            mem[i] = {tmp[21:0], 10'(i)};
        end
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 10'd0; halt = 1'b0; id_ready = 1'b1;

        // Reset state.
        @(negedge clk1); @(negedge clk1); #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_flush", 64'(id_flush), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_w_req", 64'(imem_req_w), 64'd0);
        check("rst_w_halted_flush", 64'({halted_w, id_flush_w}), 64'd0);

        // Streaming from reset, and wrap-around fetch on the 4-bit instance.
        release_reset();
        for (int c = 0; c < 12; c++) begin
            #1;
            check("stream_req", 64'(imem_req), 64'd1);
            check("stream_addr", 64'(imem_addr), 64'(c));
            if (c < 2) begin
                check("stream_valid_early", 64'(id_valid), 64'd0);
            end else begin
                check("stream_valid", 64'(id_valid), 64'd1);
                check("stream_ir", 64'(id_ir), 64'(mem[c-2]));
                check("stream_npc", 64'(id_npc), 64'(c-1));
            end
            if (c < 4) begin
                check("wrap_req", 64'(imem_req_w), 64'd1);
                check("wrap_addr", 64'(imem_addr_w), 64'((14 + c) % 16));
            end
            if (c == 2 || c == 3) begin
                check("wrap_valid", 64'(id_valid_w), 64'd1);
                check("wrap_ir", 64'(id_ir_w), 64'(32'hCAFE0000 | 32'(12 + c)));
                check("wrap_npc", 64'(id_npc_w), 64'((13 + c) % 16));
            end
            @(negedge clk1);
        end

        // Decode stalled for 10 cycles: queue fills to DEPTH, then drains in order.
        apply_reset();
        id_ready = 1'b0;
        release_reset();
        n_req = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imem_req) n_req++;
            sb_cycle();
            @(negedge clk1);
        end
        check("stall_req_count", 64'(n_req), 64'd4);
        check("stall_head_valid", 64'(id_valid), 64'd1);
        check("stall_head_ir", 64'(id_ir), 64'(mem[0]));
        id_ready = 1'b1;
        #1;
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'd4);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #1;
            sb_cycle();
            @(negedge clk1);
        end
        check("resume_throughput", 64'(hs_count), 64'd8);

        // Redirect to 20 while fetching 6 with request 5 still outstanding.
        apply_reset();
        release_reset();
        for (int c = 0; c < 10; c++) begin
            redirect_valid = (c == 6);
            redirect_pc    = 10'd20;
            #1;
            if (c == 6) check("pre_redirect_pc", 64'(fetch_pc), 64'd6);
            sb_cycle();
            if (c == 7) begin
                check("stale_dropped", 64'(id_valid), 64'd0);
                check("flush_one_cycle", 64'(id_flush), 64'd0);
            end
            if (c == 8) begin
                check("target_valid", 64'(id_valid), 64'd1);
                check("target_ir", 64'(id_ir), 64'(mem[20]));
                check("target_npc", 64'(id_npc), 64'd21);
            end
            @(negedge clk1);
        end

        // Halt together with a redirect: halt wins and sticks.
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'd100;
        #1;
        check("halt_cycle_req", 64'(imem_req), 64'd0);
        check("halt_cycle_flush", 64'(id_flush), 64'd0);
        @(negedge clk1);
        halt = 1'b0; redirect_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            redirect_valid = (c == 3);
            #1;
            check("halted_sticky", 64'(halted), 64'd1);
            check("halted_no_req", 64'(imem_req), 64'd0);
            check("halted_no_valid", 64'(id_valid), 64'd0);
            check("halted_no_flush", 64'(id_flush), 64'd0);
            @(negedge clk1);
        end
        redirect_valid = 1'b0;

        // Asynchronous reset with the queue full, then restart at RESET_PC.
        apply_reset();
        #1;
        check("reset_clears_halted", 64'(halted), 64'd0);
        id_ready = 1'b0;
        release_reset();
        for (int c = 0; c < 7; c++) begin
            #1;
            sb_cycle();
            @(negedge clk1);
        end
        #1;
        check("full_before_reset", 64'(id_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              64'({imem_req, imem_addr, id_valid, id_ir, id_npc, id_flush, halted}), 64'd0);
        id_ready = 1'b1;
        release_reset();
        for (int c = 0; c < 6; c++) begin
            #1;
            sb_cycle();
            @(negedge clk1);
        end
        check("restart_count", 64'(hs_count), 64'd4);

        // Randomized ready and redirect traffic.
        hs_count = 0;
        for (int c = 0; c < 500; c++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 10'($urandom_range(0, 1023));
            #1;
            sb_cycle();
            @(negedge clk1);
        end
        check("random_progress", 64'(hs_count >= 100), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_unit.md
PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the word-address width (1024-word memory).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the prefetch-queue depth; legal values are powers of 2 that are at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.

Interface
REQ-005 The block SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction-memory read strobe.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W bits: word address of the read.
REQ-009 The block SHALL have port imem_rdata, input, XLEN bits: read data, valid exactly one cycle after imem_req.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: taken branch resolved in EX.
REQ-011 The block SHALL have port redirect_pc, input, ADDR_W bits: the branch target.
REQ-012 The block SHALL have port halt, input, 1 bit: an HLT instruction has retired in WB.
REQ-013 The block SHALL have port id_ready, input, 1 bit: decode accepts this cycle (deasserted on an interlock).
REQ-014 The block SHALL have port id_valid, output, 1 bit: an instruction is presented to ID.
REQ-015 The block SHALL have port id_ir, output, XLEN bits: the instruction word.
REQ-016 The block SHALL have port id_npc, output, ADDR_W bits: the instruction's address + 1.
REQ-017 The block SHALL have port id_flush, output, 1 bit: a one-cycle pulse telling ID/EX to squash younger instructions.
REQ-018 The block SHALL have port halted, output, 1 bit: sticky halt status.

Function
REQ-019 The block SHALL hold the fetch PC, an in-flight flag, an epoch bit and a DEPTH-entry FIFO of {ir, npc} pairs.
REQ-020 The block SHALL assert imem_req with imem_addr=PC when !halted && !redirect_valid && (fifo_count + inflight) < DEPTH; PC then advances by 1, modulo 2^ADDR_W.
REQ-021 On the cycle after a non-killed request, the block SHALL push {imem_rdata, req_addr+1} into the FIFO.
REQ-022 A pop SHALL occur when id_valid && id_ready; a push and a pop in the same cycle SHALL be legal, including when the FIFO is full or empty.
REQ-023 The block SHALL drive id_valid = fifo_nonempty && !redirect_valid && !halted, with id_ir and id_npc taken from the FIFO head.
REQ-024 When redirect_valid is high, the block SHALL, in that cycle: clear the FIFO, toggle the epoch so that any outstanding response is dropped rather than pushed, drive imem_req=1 with imem_addr=redirect_pc, set PC to redirect_pc+1, and assert id_flush.
REQ-025 Redirect SHALL take priority over a simultaneous pop: no handshake occurs in that cycle.
REQ-026 Redirect latency SHALL be: the target instruction is presented on id_valid 2 cycles after the redirect cycle when id_ready=1.
REQ-027 The halt input SHALL set halted (sticky until reset); once halted, the block SHALL issue no further requests, hold id_valid low, drop any outstanding response, and ignore redirect_valid.
REQ-028 Halt SHALL take priority over a simultaneous redirect.
REQ-029 With id_ready held high and no redirect, steady-state throughput SHALL be 1 instruction per cycle for DEPTH ≥ 2.
REQ-030 While id_ready is low, the FIFO SHALL fill to DEPTH and stall with no overflow and no lost or duplicated instruction.

Reset
REQ-031 While rst_n=0, the block SHALL set PC=RESET_PC, clear the FIFO, clear inflight and epoch, set halted=0, and drive imem_req=0, id_valid=0 and id_flush=0.
REQ-032 The block SHALL issue its first request in the first clk1 edge after rst_n deasserts.
REQ-033 Asserting reset mid-operation SHALL discard all queued and in-flight instructions.

Structure
REQ-034 Package riscv_pipe_pkg SHALL hold the opcode constants (ADD..BEQZ, HLT=6'b111111), the instruction-type codes (RR_ALU..HAT) and the default XLEN/ADDR_W.
REQ-035 The queue SHALL be a sub-module fetch_fifo, parametrised by width and DEPTH, providing push, pop, flush, count, full and empty.
REQ-036 The clock SHALL be single-phase clk1 only; no second phase and no #delays.

Verification
REQ-037 Memory[0..7]=distinct words, id_ready=1 -> id_ir sequence Mem[0],Mem[1],... with id_npc 1,2,...; id_valid every cycle from cycle 2.
REQ-038 Hold id_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 requests issued; on release, Mem[0..3] are presented in order and then fetching resumes at 4.
REQ-039 Assert redirect_valid with redirect_pc=20 while PC=6 and a request is outstanding -> id_flush pulses, the stale word is not presented, and the next id_ir=Mem[20] with id_npc=21 two cycles later.
REQ-040 Assert halt and redirect_valid in the same cycle -> halted=1, imem_req stays 0 and id_valid stays 0 thereafter.
REQ-041 With ADDR_W=4, start at PC=14 -> fetch order 14, 15, 0, 1.
REQ-042 Pulse rst_n low mid-stream with the FIFO full -> all outputs are 0 asynchronously, and after release fetching restarts at RESET_PC.
